// File: rtl/trigger_unit_if.sv
// Bundles the trigger unit's control, probe and result signals.
// The trigger unit uses the slave modport; the driving side uses master.
interface trigger_unit_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned CNT_W = 32;

  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] levelMask;
  logic [WIDTH-1:0] edgeMask;
  logic [CNT_W-1:0] matchCount;
  logic             arm;
  logic             abort;
  logic             captureDone;
  logic             trigStart;
  logic             armed;
  logic             triggered;
  logic [WIDTH-1:0] trigSample;

  modport master (
    output dataIn, pattern, levelMask, edgeMask, matchCount, arm, abort, captureDone,
    input  trigStart, armed, triggered, trigSample
  );

  modport slave (
    input  dataIn, pattern, levelMask, edgeMask, matchCount, arm, abort, captureDone,
    output trigStart, armed, triggered, trigSample
  );
endinterface

// File: rtl/trigger_unit.sv
// Pattern/edge trigger detector feeding the capture pulse generator.
// Define TRIGGER_EDGE_EN to enable the edge term and the prev sample register.
module trigger_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  trigger_unit_if.slave bus_if
);
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_q;
  logic [WIDTH-1:0] trig_sample_q, trig_sample_d;
  logic             trig_start_q, trig_start_d;
  logic             armed_q, armed_d;
  logic             triggered_q, triggered_d;

  logic             level_ok;
  logic             edge_ok;
  logic             match;
  logic             hit;
  logic [CNT_W-1:0] target;

  assign level_ok = ((cur_q ^ bus_if.pattern) & bus_if.levelMask) == '0;

`ifdef TRIGGER_EDGE_EN
  logic [WIDTH-1:0] prev_q;

  // Every edge-masked bit must have toggled and landed on its pattern value.
  assign edge_ok = ((~(prev_q ^ cur_q) | (cur_q ^ bus_if.pattern)) & bus_if.edgeMask) == '0;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= cur_q;
  end
`else
  logic unused_edge_mask;
  assign unused_edge_mask = ^bus_if.edgeMask;
  assign edge_ok          = 1'b1;
`endif

  assign match  = level_ok & edge_ok;
  assign target = (bus_if.matchCount == CNT_W'(0)) ? CNT_W'(0) : bus_if.matchCount - CNT_W'(1);
  assign hit    = match && (cnt_q >= target);

  // State register plus the registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cur_q         <= '0;
      trig_sample_q <= '0;
      trig_start_q  <= 1'b0;
      armed_q       <= 1'b0;
      triggered_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_q         <= bus_if.dataIn;
      trig_sample_q <= trig_sample_d;
      trig_start_q  <= trig_start_d;
      armed_q       <= armed_d;
      triggered_q   <= triggered_d;
    end
  end

  // Next state; abort overrides everything, arm while armed restarts in place.
  always_comb begin
    state_d = state_q;
    if (bus_if.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (bus_if.arm) state_d = S_ARMED;
        S_ARMED: if (!bus_if.arm && hit) state_d = S_FIRED;
        S_FIRED: if (bus_if.captureDone) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counter, trigger pulse and captured sample for the next cycle.
  always_comb begin
    cnt_d         = cnt_q;
    trig_start_d  = 1'b0;
    trig_sample_d = trig_sample_q;
    if (bus_if.abort) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus_if.arm) cnt_d = '0;
        S_ARMED: begin
          if (bus_if.arm || !match) begin
            cnt_d = '0;
          end else if (hit) begin
            trig_start_d  = 1'b1;
            trig_sample_d = cur_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
    armed_d     = (state_d == S_ARMED);
    triggered_d = (state_d == S_FIRED);
  end

  assign bus_if.trigStart  = trig_start_q;
  assign bus_if.armed      = armed_q;
  assign bus_if.triggered  = triggered_q;
  assign bus_if.trigSample = trig_sample_q;
endmodule

// File: tb/tb_trigger_unit.sv
// Scoreboard bench for trigger_unit: stimulus queues expected trigger events,
// a monitor pops and checks them whenever trigStart is seen.
module tb_trigger_unit;
  localparam int unsigned WIDTH = 16;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] sample;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  trigger_unit_if #(.WIDTH(WIDTH)) bus();

  trigger_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every trigStart must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (bus.trigStart === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_trigStart: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("trig_cycle", 32'(cyc), 32'(e.cyc));
        check("trig_sample", 32'(bus.trigSample), 32'(e.sample));
        check("trig_triggered", 32'(bus.triggered), 32'd1);
      end
    end
  end

  // One cycle of stimulus applied at the negedge; queues a trigger if expected.
  task automatic drive(input logic [WIDTH-1:0] d, input logic a, input logic ab,
                       input logic cd, input logic fire);
    exp_t e;
    bus.dataIn      = d;
    bus.arm         = a;
    bus.abort       = ab;
    bus.captureDone = cd;
    if (fire) begin
      e.cyc    = cyc + 2;
      e.sample = d;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic a, input logic t,
                            input logic [WIDTH-1:0] s);
    check({tag, "_armed"}, 32'(bus.armed), 32'(a));
    check({tag, "_triggered"}, 32'(bus.triggered), 32'(t));
    check({tag, "_trigSample"}, 32'(bus.trigSample), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.dataIn      = '0;
    bus.pattern     = '0;
    bus.levelMask   = '0;
    bus.edgeMask    = '0;
    bus.matchCount  = 32'd1;
    bus.arm         = 1'b0;
    bus.abort       = 1'b0;
    bus.captureDone = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trigStart", 32'(bus.trigStart), 32'd0);
    check_outs("rst", 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // Level match, count 1
    bus.levelMask  = 16'h00FF;
    bus.pattern    = 16'h00A5;
    bus.matchCount = 32'd1;
    drive(16'h0000, 1, 0, 0, 0);
    check_outs("lvl_armed", 1'b1, 1'b0, 16'h0000);
    drive(16'h12A5, 0, 0, 0, 1);
    drive(16'h0000, 0, 0, 0, 0);
    check_outs("lvl_fired", 1'b0, 1'b1, 16'h12A5);
    drive(16'h0000, 0, 0, 1, 0);
    check_outs("lvl_done", 1'b0, 1'b0, 16'h12A5);

    // Three consecutive matches required; a miss restarts the run
    bus.matchCount = 32'd3;
    drive(16'h0000, 1, 0, 0, 0);
    drive(16'h34A5, 0, 0, 0, 0);
    drive(16'h34A5, 0, 0, 0, 0);
    drive(16'h3400, 0, 0, 0, 0);
    drive(16'h56A5, 0, 0, 0, 0);
    drive(16'h56A5, 0, 0, 0, 0);
    drive(16'h78A5, 0, 0, 0, 1);
    drive(16'h0000, 0, 0, 0, 0);
    // Holdoff: matches and arm while fired do nothing
    drive(16'h00A5, 1, 0, 0, 0);
    drive(16'h00A5, 1, 0, 0, 0);
    drive(16'h00A5, 0, 0, 0, 0);
    check_outs("hold", 1'b0, 1'b1, 16'h78A5);
    drive(16'h0000, 0, 0, 1, 0);
    check_outs("hold_done", 1'b0, 1'b0, 16'h78A5);
    bus.matchCount = 32'd1;
    drive(16'h0000, 1, 0, 0, 0);
    drive(16'h9AA5, 0, 0, 0, 1);
    drive(16'h0000, 0, 0, 0, 0);
    drive(16'h0000, 0, 0, 1, 0);

    // Abort with arm and a matching sample in cur
    drive(16'h0000, 1, 0, 0, 0);
    drive(16'h55A5, 0, 0, 0, 0);
    drive(16'h55A5, 1, 1, 0, 0);
    check_outs("abort", 1'b0, 1'b0, 16'h9AA5);
    drive(16'h55A5, 0, 0, 0, 0);
    drive(16'h55A5, 0, 0, 0, 0);
    check_outs("abort_idle", 1'b0, 1'b0, 16'h9AA5);

`ifdef TRIGGER_EDGE_EN
    // Rising edge on bit 0 only
    bus.levelMask = 16'h0000;
    bus.edgeMask  = 16'h0001;
    bus.pattern   = 16'h0001;
    drive(16'h0001, 0, 0, 0, 0);
    drive(16'h0001, 0, 0, 0, 0);
    drive(16'h0001, 1, 0, 0, 0);
    drive(16'h0001, 0, 0, 0, 0);
    drive(16'h0001, 0, 0, 0, 0);
    check_outs("edge_hold1", 1'b1, 1'b0, 16'h9AA5);
    drive(16'h0000, 0, 0, 0, 0);
    drive(16'h0001, 0, 0, 0, 1);
    drive(16'h0001, 0, 0, 0, 0);
    check_outs("edge_fired", 1'b0, 1'b1, 16'h0001);
    drive(16'h0000, 0, 0, 1, 0);
    bus.edgeMask = 16'h0000;
`endif

    // matchCount 0 with no masks: first evaluated sample fires
    bus.levelMask  = 16'h0000;
    bus.edgeMask   = 16'h0000;
    bus.matchCount = 32'd0;
    drive(16'h0BAD, 1, 0, 0, 1);
    drive(16'h1111, 0, 0, 0, 0);
    check_outs("mc0", 1'b0, 1'b1, 16'h0BAD);
    drive(16'h2222, 0, 0, 1, 0);

    // Reset with arm in the same cycle
    reset = 1'b1;
    drive(16'h0C0C, 1, 0, 0, 0);
    check("rstarm_trigStart", 32'(bus.trigStart), 32'd0);
    check_outs("rstarm", 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    drive(16'h0D0D, 0, 0, 0, 0);
    drive(16'h0E0E, 0, 0, 0, 0);
    check_outs("rstarm_after", 1'b0, 1'b0, 16'h0000);

    repeat (4) drive(16'h0000, 0, 0, 0, 0);
    check("pending_triggers", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
